// File: rtl/uart_wb_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | uart_wb_master: WISHBONE initiator that programs, polls and feeds a MiniUART. |
// | Optional: `define UART_WB_MASTER_STATS_EN adds tx_count/rx_count. Rev 1.0    |
// +-----------------------------------------------------------------------------+
module uart_wb_master #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIVR_INIT  = 16'd5208,
  parameter logic [15:0] DIVT_INIT  = 16'd5208,
  parameter int unsigned TX_GUARD   = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [4:2]  ADD_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy
`ifdef UART_WB_MASTER_STATS_EN
  ,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (TX_GUARD > 1) ? $clog2(TX_GUARD) : 1;

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_LSR  = 3'd1;
  localparam logic [2:0] A_DIVR = 3'd2;
  localparam logic [2:0] A_DIVT = 3'd3;

  typedef enum logic [2:0] {
    S_INIT_DIVR, S_INIT_DIVT, S_POLL, S_RX_READ, S_RX_CLR, S_TX_WRITE, S_GUARD
  } state_t;

  state_t          state_q;
  logic            stb_q, we_q;
  logic [2:0]      add_q;
  logic [31:0]     dat_q;
  logic            rx_valid_q;
  logic [7:0]      rx_data_q;
  logic [GW-1:0]   guard_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop, fifo_nonempty;
  logic [5:0]      lsr;
  logic            unused_dat;

  assign lsr           = DAT_I[5:0];
  assign unused_dat    = ^DAT_I[31:8];
  assign fifo_nonempty = (count_q != '0);
  assign tx_ready      = (count_q != CW'(FIFO_DEPTH));
  assign push          = tx_valid && tx_ready;
  assign pop           = (state_q == S_TX_WRITE) && stb_q && ACK_I;

  assign ADD_O    = add_q;
  assign DAT_O    = dat_q;
  assign STB_O    = stb_q;
  assign WE_O     = we_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q == S_INIT_DIVR) || (state_q == S_INIT_DIVT) || fifo_nonempty;

  // Every access state launches its strobe on entry (after the one-cycle gap)
  // and holds all bus fields until ACK_I; GUARD launches the next LSR read itself.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= S_INIT_DIVR;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      add_q      <= 3'd0;
      dat_q      <= 32'd0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
      guard_q    <= '0;
    end else begin
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (state_q)
        S_INIT_DIVR: begin
          if (!stb_q) begin
            stb_q <= 1'b1; we_q <= 1'b1; add_q <= A_DIVR; dat_q <= {16'd0, DIVR_INIT};
          end else if (ACK_I) begin
            stb_q <= 1'b0; state_q <= S_INIT_DIVT;
          end
        end
        S_INIT_DIVT: begin
          if (!stb_q) begin
            stb_q <= 1'b1; we_q <= 1'b1; add_q <= A_DIVT; dat_q <= {16'd0, DIVT_INIT};
          end else if (ACK_I) begin
            stb_q <= 1'b0; state_q <= S_POLL;
          end
        end
        S_POLL: begin
          if (!stb_q) begin
            stb_q <= 1'b1; we_q <= 1'b0; add_q <= A_LSR; dat_q <= 32'd0;
          end else if (ACK_I) begin
            stb_q <= 1'b0;
            if (lsr[0] && !rx_valid_q)         state_q <= S_RX_READ;
            else if (lsr[5] && fifo_nonempty)  state_q <= S_TX_WRITE;
            else                               state_q <= S_POLL;
          end
        end
        S_RX_READ: begin
          if (!stb_q) begin
            stb_q <= 1'b1; we_q <= 1'b0; add_q <= A_DATA; dat_q <= 32'd0;
          end else if (ACK_I) begin
            stb_q      <= 1'b0;
            rx_data_q  <= DAT_I[7:0];
            rx_valid_q <= 1'b1;
            state_q    <= S_RX_CLR;
          end
        end
        S_RX_CLR: begin
          if (!stb_q) begin
            stb_q <= 1'b1; we_q <= 1'b1; add_q <= A_LSR; dat_q <= 32'd0;
          end else if (ACK_I) begin
            stb_q <= 1'b0; state_q <= S_POLL;
          end
        end
        S_TX_WRITE: begin
          if (!stb_q) begin
            stb_q <= 1'b1; we_q <= 1'b1; add_q <= A_DATA; dat_q <= {24'd0, mem_q[rd_ptr_q]};
          end else if (ACK_I) begin
            stb_q <= 1'b0; guard_q <= '0; state_q <= S_GUARD;
          end
        end
        S_GUARD: begin
          // The slave's ts flag lags the DATA load, so LSR is not trusted until this expires.
          if (guard_q == GW'(TX_GUARD - 1)) begin
            state_q <= S_POLL;
            stb_q <= 1'b1; we_q <= 1'b0; add_q <= A_LSR; dat_q <= 32'd0;
          end else begin
            guard_q <= guard_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_INIT_DIVR;
          stb_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

`ifdef UART_WB_MASTER_STATS_EN
  logic [15:0] tx_count_q, rx_count_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      tx_count_q <= 16'd0;
      rx_count_q <= 16'd0;
    end else begin
      if (pop) tx_count_q <= tx_count_q + 16'd1;
      if ((state_q == S_RX_READ) && stb_q && ACK_I) rx_count_q <= rx_count_q + 16'd1;
    end
  end

  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
`endif

endmodule
`default_nettype wire
